lf_sum_stage: RTL and testbench

- Final post-processing stage of the Ladner-Fischer adder. It sits downstream of the last prefix level.
- Consumes bitwise propagate bits and full-span group generates (G[i:0], with carry-in already folded into bit 0), plus the carry-in.
- Produces sum, carry-out, signed overflow and zero flags through a registered valid/ready output.
- A 2-entry skid buffer sustains one result per cycle under backpressure.

---
 rtl/lf_sum_stage.sv | 109 ++++++++++
 tb/tb_lf_sum_stage.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/lf_sum_stage.sv
// lf_sum_stage
//   Final stage of the Ladner-Fischer adder. Takes the bitwise propagate bits
//   and the full-span group generates from the last prefix level. It forms
//   sum, carry-out, signed overflow and zero, and presents them on a
//   registered valid/ready output. A two-entry skid buffer keeps throughput
//   at one result per cycle under backpressure.
//
// Parameters
//   WIDTH  adder width in bits (>= 2)
//   CNT_W  width of the saturating completed-result counter
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   upstream result valid
//   in_ready   stage can accept (driven from the skid flag register)
//   p_in       bitwise propagate a[i]^b[i]
//   g_grp      group generate G[i:0] (carry out of bit i, cin folded in)
//   cin        adder carry-in
//   out_valid  result valid
//   out_ready  downstream accepts result
//   sum        a+b+cin mod 2^WIDTH
//   cout       carry out of the MSB
//   ovf        two's-complement overflow
//   zero       sum == 0
//   res_cnt    saturating count of results consumed downstream
module lf_sum_stage #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] p_in,
    input  logic [WIDTH-1:0] g_grp,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero,
    output logic [CNT_W-1:0] res_cnt
);

    // Payload layout: {sum, cout, ovf, zero}
    localparam int PW = WIDTH + 3;

    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] s;
    logic [PW-1:0]    in_pl;
    logic [PW-1:0]    main_pl;
    logic [PW-1:0]    skid_pl;
    logic             skid_v;
    logic             accept;
    logic             drain;

    // Carry into bit i is the group generate of bits [i-1:0]; cin feeds bit 0.
    always_comb begin
        carry = {g_grp[WIDTH-2:0], cin};
        s     = p_in ^ carry;
        in_pl = {s, g_grp[WIDTH-1], g_grp[WIDTH-1] ^ g_grp[WIDTH-2], (s == '0)};
    end

    // Ready depends only on the skid register, never on out_ready.
    assign in_ready = ~skid_v;
    assign accept   = in_valid & in_ready;
    assign drain    = out_valid & out_ready;

    assign {sum, cout, ovf, zero} = main_pl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            skid_v    <= 1'b0;
            main_pl   <= '0;
            skid_pl   <= '0;
        end else if (!out_valid || out_ready) begin
            // Main register is free this cycle.
            if (skid_v) begin
                main_pl   <= skid_pl;
                out_valid <= 1'b1;
                skid_v    <= accept;
                if (accept) begin
                    skid_pl <= in_pl;
                end
            end else if (accept) begin
                main_pl   <= in_pl;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end else if (accept) begin
            // Main stalled: park the new result in the skid register.
            skid_pl <= in_pl;
            skid_v  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_cnt <= '0;
        end else if (drain && (res_cnt != '1)) begin
            res_cnt <= res_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_lf_sum_stage.sv
// tb_lf_sum_stage
//   Table-driven bench for lf_sum_stage (WIDTH=32). A second instance with
//   CNT_W=2 shares the inputs and is used to observe counter saturation.
module tb_lf_sum_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] p_in;
    logic [31:0] g_grp;
    logic        cin;

    logic        in_ready, out_valid, cout, ovf, zero;
    logic [31:0] sum;
    logic [15:0] res_cnt;

    logic        in_ready2, out_valid2, cout2, ovf2, zero2;
    logic [31:0] sum2;
    logic [1:0]  res_cnt2;

    int n_pass;
    int n_total;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        ci;
        logic [31:0] s;
        logic        co;
        logic        ov;
        logic        z;
    } vec_t;

    vec_t tbl [8];

    lf_sum_stage #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .p_in(p_in), .g_grp(g_grp), .cin(cin), .out_valid(out_valid),
        .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf),
        .zero(zero), .res_cnt(res_cnt)
    );

    lf_sum_stage #(.WIDTH(32), .CNT_W(2)) dut_small (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2),
        .p_in(p_in), .g_grp(g_grp), .cin(cin), .out_valid(out_valid2),
        .out_ready(out_ready), .sum(sum2), .cout(cout2), .ovf(ovf2),
        .zero(zero2), .res_cnt(res_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached before completion");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands as the prefix tree would: propagate bits and ripple-derived group generates.
    task automatic drive(input int i);
        logic c;
        logic [31:0] p;
        logic [31:0] g;
        p = tbl[i].a ^ tbl[i].b;
        c = tbl[i].ci;
        for (int unsigned k = 0; k < 32; k++) begin
            g[k] = (tbl[i].a[k] & tbl[i].b[k]) | (p[k] & c);
            c = g[k];
        end
        p_in  = p;
        g_grp = g;
        cin   = tbl[i].ci;
    endtask

    task automatic check_out(input int i, input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd1);
        check({tag, ".sum"},       64'(sum),       64'(tbl[i].s));
        check({tag, ".cout"},      64'(cout),      64'(tbl[i].co));
        check({tag, ".ovf"},       64'(ovf),       64'(tbl[i].ov));
        check({tag, ".zero"},      64'(zero),      64'(tbl[i].z));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, ".out_valid"}, 64'(out_valid), 64'd0);
        check({tag, ".in_ready"},  64'(in_ready),  64'd1);
        check({tag, ".sum"},       64'(sum),       64'd0);
        check({tag, ".cout"},      64'(cout),      64'd0);
        check({tag, ".ovf"},       64'(ovf),       64'd0);
        check({tag, ".zero"},      64'(zero),      64'd0);
        check({tag, ".res_cnt"},   64'(res_cnt),   64'd0);
        check({tag, ".res_cnt2"},  64'(res_cnt2),  64'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
    endtask

    initial begin
        //            a             b             ci    sum           co    ov    z
        tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{32'h00000005, 32'h00000003, 1'b1, 32'h00000009, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
        tbl[4] = '{32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
        tbl[5] = '{32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0};
        tbl[7] = '{32'h40000000, 32'h40000000, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};

        n_pass    = 0;
        n_total   = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        p_in      = '0;
        g_grp     = '0;
        cin       = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check_reset_state("por");
        rst = 1'b0;

        // Single results, one at a time, one-cycle latency
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            drive(i);
            in_valid = 1'b1;
            check($sformatf("single%0d.in_ready", i), 64'(in_ready), 64'd1);
            @(negedge clk);
            in_valid = 1'b0;
            check_out(i, $sformatf("single%0d", i));
        end
        @(negedge clk);
        check("single.idle_valid", 64'(out_valid), 64'd0);
        check("single.res_cnt", 64'(res_cnt), 64'd8);

        // Back-to-back stream; small counter sees 1,2,3,3,3 as drains accumulate
        do_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check_out(i - 1, $sformatf("stream%0d", i - 1));
                check($sformatf("stream%0d.res_cnt", i - 1), 64'(res_cnt), 64'(i - 1));
                check($sformatf("stream%0d.res_cnt2", i - 1), 64'(res_cnt2),
                      64'((i - 1) > 3 ? 3 : (i - 1)));
            end
            drive(i);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_out(7, "stream7");
        @(negedge clk);
        check("stream.end_valid", 64'(out_valid), 64'd0);
        check("stream.res_cnt", 64'(res_cnt), 64'd8);
        check("stream.res_cnt2", 64'(res_cnt2), 64'd3);

        // Stall: two accepted, third held upstream, then drained in order
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        drive(3);
        in_valid = 1'b1;
        check("stall.ready0", 64'(in_ready), 64'd1);
        @(negedge clk);
        check("stall.ready1", 64'(in_ready), 64'd1);
        check_out(3, "stall.first");
        drive(5);
        @(negedge clk);
        check("stall.ready2", 64'(in_ready), 64'd0);
        drive(6);
        @(negedge clk);
        check("stall.ready_held", 64'(in_ready), 64'd0);
        check_out(3, "stall.hold");
        out_ready = 1'b1;
        @(negedge clk);
        check_out(5, "stall.second");
        check("stall.ready_back", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check_out(6, "stall.third");
        @(negedge clk);
        check("stall.empty", 64'(out_valid), 64'd0);
        check("stall.res_cnt", 64'(res_cnt), 64'd3);

        // Asynchronous reset while two entries are held
        @(negedge clk);
        out_ready = 1'b0;
        drive(1);
        in_valid = 1'b1;
        @(negedge clk);
        drive(7);
        @(negedge clk);
        in_valid = 1'b0;
        check("midrst.full", 64'(in_ready), 64'd0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_state("midrst");
        @(negedge clk);
        rst = 1'b0;
        check("midrst.after_valid", 64'(out_valid), 64'd0);
        check("midrst.after_ready", 64'(in_ready), 64'd1);
        drive(2);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check_out(2, "midrst.new");
        @(negedge clk);
        check("midrst.drained", 64'(out_valid), 64'd0);
        check("midrst.res_cnt", 64'(res_cnt), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
